// File: rtl/pokey_keyboard_scanner.sv
// POKEY keyboard matrix sequencer: walks the 6-bit scan count, debounces key
// returns, latches KBCODE with shift/ctrl, and pulses the key interrupt.
module pokey_keyboard_scanner #(
    parameter logic [5:0] SHIFT_POS = 6'h30,
    parameter logic [5:0] CTRL_POS  = 6'h3F
) (
    input  logic       clk,
    input  logic       rst_L,
    input  logic       tick,
    input  logic       scan_en,
    input  logic       debounce_en,
    input  logic       kr1_L,
    input  logic       kr2_L,
    output logic [5:0] key_scan_L,
    output logic [7:0] kbcode,
    output logic       key_irq,
    output logic       key_down
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    state_t     state;
    logic [5:0] cnt;
    logic [5:0] cmp;
    logic       shift_r;
    logic       ctrl_r;

    logic       hit;
    logic       at_cmp;
    logic [7:0] new_code;

    assign hit        = ~kr1_L;
    assign at_cmp     = (cnt == cmp);
    assign new_code   = {ctrl_r, shift_r, cnt};
    assign key_scan_L = ~cnt;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state    <= IDLE;
            cnt      <= 6'h00;
            cmp      <= 6'h00;
            shift_r  <= 1'b0;
            ctrl_r   <= 1'b0;
            kbcode   <= 8'h00;
            key_irq  <= 1'b0;
            key_down <= 1'b0;
        end else begin
            // NOTE: key_irq defaults low every edge so an accept yields exactly one clk of pulse.
            key_irq <= 1'b0;

            if (!scan_en) begin
                state    <= IDLE;
                key_down <= 1'b0;
            end else if (tick) begin
                cnt <= cnt + 6'd1;
                if (cnt == SHIFT_POS) shift_r <= ~kr2_L;
                if (cnt == CTRL_POS)  ctrl_r  <= ~kr2_L;

                case (state)
                    IDLE: begin
                        if (hit) begin
                            cmp <= cnt;
                            if (debounce_en) begin
                                state <= DEBOUNCE;
                            end else begin
                                kbcode   <= new_code;
                                key_irq  <= 1'b1;
                                state    <= HELD;
                                key_down <= 1'b1;
                            end
                        end
                    end

                    // Only the count that started debounce is examined, one pass later.
                    DEBOUNCE: begin
                        if (at_cmp) begin
                            if (hit) begin
                                kbcode   <= new_code;
                                key_irq  <= 1'b1;
                                state    <= HELD;
                                key_down <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end

                    HELD: begin
                        if (at_cmp && !hit) begin
                            state    <= IDLE;
                            key_down <= 1'b0;
                        end
                    end

                    default: begin
                        state    <= IDLE;
                        key_down <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pokey_keyboard_scanner.sv
// Self-checking bench for pokey_keyboard_scanner: a key-slot reference model
// (candidate key / held key) is advanced alongside the DUT and compared every cycle.
module tb_pokey_keyboard_scanner;

    logic       clk = 1'b0;
    logic       rst_L;
    logic       tick;
    logic       scan_en;
    logic       debounce_en;
    logic       kr1_L;
    logic       kr2_L;
    logic [5:0] key_scan_L;
    logic [7:0] kbcode;
    logic       key_irq;
    logic       key_down;

    pokey_keyboard_scanner dut (
        .clk         (clk),
        .rst_L       (rst_L),
        .tick        (tick),
        .scan_en     (scan_en),
        .debounce_en (debounce_en),
        .kr1_L       (kr1_L),
        .kr2_L       (kr2_L),
        .key_scan_L  (key_scan_L),
        .kbcode      (kbcode),
        .key_irq     (key_irq),
        .key_down    (key_down)
    );

    always #5 clk = ~clk;

    // Keyboard matrix: pressed keys answer on kr1_L when their row is selected.
    logic [63:0] keys;
    logic        shift_key;
    logic        ctrl_key;
    logic [5:0]  scan_cnt;

    assign scan_cnt = ~key_scan_L;
    assign kr1_L    = ~keys[scan_cnt];
    assign kr2_L    = ~((scan_cnt == 6'h30 && shift_key) || (scan_cnt == 6'h3F && ctrl_key));

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: position, latched modifiers, last code, and key slots.
    int         m_cnt;
    bit         m_shift;
    bit         m_ctrl;
    logic [7:0] m_kbcode;
    bit         m_irq;
    int         cand;   // key waiting for its confirming pass, -1 if none
    int         held;   // accepted key still down, -1 if none

    task automatic model_reset();
        m_cnt    = 0;
        m_shift  = 0;
        m_ctrl   = 0;
        m_kbcode = 8'h00;
        m_irq    = 0;
        cand     = -1;
        held     = -1;
    endtask

    task automatic model_edge();
        bit hit;
        m_irq = 0;
        if (!scan_en) begin
            cand = -1;
            held = -1;
        end else if (tick) begin
            hit = keys[m_cnt];
            if (held >= 0) begin
                if (m_cnt == held && !hit) held = -1;
            end else if (cand >= 0) begin
                if (m_cnt == cand) begin
                    cand = -1;
                    if (hit) begin
                        m_kbcode = {m_ctrl, m_shift, 6'(m_cnt)};
                        m_irq    = 1;
                        held     = m_cnt;
                    end
                end
            end else if (hit) begin
                if (debounce_en) begin
                    cand = m_cnt;
                end else begin
                    m_kbcode = {m_ctrl, m_shift, 6'(m_cnt)};
                    m_irq    = 1;
                    held     = m_cnt;
                end
            end
            if (m_cnt == 48) m_shift = shift_key;
            if (m_cnt == 63) m_ctrl  = ctrl_key;
            m_cnt = (m_cnt + 1) % 64;
        end
    endtask

    function automatic logic [15:0] dut_obs();
        return {key_scan_L, kbcode, key_irq, key_down};
    endfunction

    function automatic logic [15:0] exp_obs();
        return {6'(63 - m_cnt), m_kbcode, m_irq, held >= 0};
    endfunction

    // One clock edge with the given tick/scan_en; leaves time at posedge+1.
    task automatic do_step(input bit t, input bit e);
        tick    = t;
        scan_en = e;
        model_edge();
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic goto_cnt(input int target);
        for (int i = 0; i < 64 && m_cnt != target; i++) do_step(1'b1, 1'b1);
    endtask

    task automatic test_reset();
        rst_L = 1'b0; tick = 1'b0; scan_en = 1'b0; debounce_en = 1'b0;
        keys = '0; shift_key = 1'b0; ctrl_key = 1'b0;
        model_reset();
        #12;
        vectors++;
        if (dut_obs() !== {6'h3F, 8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected %h", dut_obs(), {6'h3F, 8'h00, 1'b0, 1'b0});
        end
        rst_L = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            do_step(1'b1, 1'b1);
            vectors++;
            if (dut_obs() !== exp_obs()) begin
                miscompares++;
                $display("FAIL reset_first_steps %0d: got %h expected %h", i, dut_obs(), exp_obs());
            end
        end
    endtask

    task automatic test_debounce_on();
        int irqs = 0;
        debounce_en = 1'b1;
        goto_cnt(6'h12);
        keys[6'h12] = 1'b1;
        for (int i = 0; i <= 64; i++) begin
            do_step(1'b1, 1'b1);
            irqs += int'(key_irq);
            vectors++;
            if (dut_obs() !== exp_obs()) begin
                miscompares++;
                $display("FAIL debounce_on step %0d: got %h expected %h", i, dut_obs(), exp_obs());
            end
        end
        vectors++;
        if (irqs !== 1 || key_irq !== 1'b1 || kbcode !== 8'h12 || key_down !== 1'b1) begin
            miscompares++;
            $display("FAIL debounce_on_accept: irqs=%0d irq=%b kbcode=%h down=%b expected irqs=1 irq=1 kbcode=12 down=1",
                     irqs, key_irq, kbcode, key_down);
        end
        keys[6'h12] = 1'b0;
        goto_cnt(6'h12);
        vectors++;
        if (key_down !== 1'b1) begin
            miscompares++;
            $display("FAIL debounce_on_still_held: got %b expected 1", key_down);
        end
        do_step(1'b1, 1'b1);
        vectors++;
        if (key_down !== 1'b0 || dut_obs() !== exp_obs()) begin
            miscompares++;
            $display("FAIL debounce_on_release: down=%b obs %h expected down=0 obs %h", key_down, dut_obs(), exp_obs());
        end
    endtask

    task automatic test_glitch();
        int irqs = 0;
        debounce_en = 1'b1;
        goto_cnt(6'h05);
        keys[6'h05] = 1'b1;
        do_step(1'b1, 1'b1);
        keys[6'h05] = 1'b0;
        for (int i = 0; i < 70; i++) begin
            do_step(1'b1, 1'b1);
            irqs += int'(key_irq);
            vectors++;
            if (dut_obs() !== exp_obs()) begin
                miscompares++;
                $display("FAIL glitch step %0d: got %h expected %h", i, dut_obs(), exp_obs());
            end
        end
        vectors++;
        if (irqs !== 0 || kbcode !== 8'h12 || key_down !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_rejected: irqs=%0d kbcode=%h down=%b expected irqs=0 kbcode=12 down=0",
                     irqs, kbcode, key_down);
        end
    endtask

    task automatic test_debounce_off();
        debounce_en = 1'b0;
        shift_key   = 1'b1;
        goto_cnt(6'h30);
        do_step(1'b1, 1'b1);
        keys[6'h2A] = 1'b1;
        goto_cnt(6'h2A);
        do_step(1'b1, 1'b1);
        vectors++;
        if (key_irq !== 1'b1 || kbcode !== 8'h6A || key_down !== 1'b1) begin
            miscompares++;
            $display("FAIL debounce_off_accept: irq=%b kbcode=%h down=%b expected irq=1 kbcode=6a down=1",
                     key_irq, kbcode, key_down);
        end
        do_step(1'b1, 1'b1);
        vectors++;
        if (key_irq !== 1'b0) begin
            miscompares++;
            $display("FAIL debounce_off_irq_width: got %b expected 0", key_irq);
        end
        keys[6'h2A] = 1'b0;
        shift_key   = 1'b0;
        for (int i = 0; i < 66; i++) begin
            do_step(1'b1, 1'b1);
            vectors++;
            if (dut_obs() !== exp_obs()) begin
                miscompares++;
                $display("FAIL debounce_off_release step %0d: got %h expected %h", i, dut_obs(), exp_obs());
            end
        end
    endtask

    task automatic test_second_key();
        int irqs = 0;
        debounce_en = 1'b1;
        goto_cnt(6'h12);
        keys[6'h12] = 1'b1;
        for (int i = 0; i <= 64; i++) do_step(1'b1, 1'b1);
        keys[6'h20] = 1'b1;
        for (int i = 0; i < 64; i++) begin
            do_step(1'b1, 1'b1);
            irqs += int'(key_irq);
        end
        vectors++;
        if (irqs !== 0 || kbcode !== 8'h12 || key_down !== 1'b1) begin
            miscompares++;
            $display("FAIL second_key_ignored: irqs=%0d kbcode=%h down=%b expected irqs=0 kbcode=12 down=1",
                     irqs, kbcode, key_down);
        end
        keys[6'h12] = 1'b0;
        for (int i = 0; i < 160; i++) begin
            do_step(1'b1, 1'b1);
            irqs += int'(key_irq);
            vectors++;
            if (dut_obs() !== exp_obs()) begin
                miscompares++;
                $display("FAIL second_key step %0d: got %h expected %h", i, dut_obs(), exp_obs());
            end
        end
        vectors++;
        if (irqs !== 1 || kbcode !== 8'h20 || key_down !== 1'b1) begin
            miscompares++;
            $display("FAIL second_key_accept: irqs=%0d kbcode=%h down=%b expected irqs=1 kbcode=20 down=1",
                     irqs, kbcode, key_down);
        end
        keys[6'h20] = 1'b0;
        for (int i = 0; i < 64; i++) do_step(1'b1, 1'b1);
    endtask

    task automatic test_wrap_and_disable();
        logic [5:0] frozen;
        goto_cnt(6'h3F);
        do_step(1'b1, 1'b1);
        vectors++;
        if (key_scan_L !== 6'h3F) begin
            miscompares++;
            $display("FAIL wrap: key_scan_L got %h expected 3f", key_scan_L);
        end
        debounce_en = 1'b0;
        keys[6'h08] = 1'b1;
        goto_cnt(6'h08);
        for (int i = 0; i < 5; i++) do_step(1'b1, 1'b1);
        frozen = key_scan_L;
        for (int i = 0; i < 6; i++) begin
            do_step(1'b1, 1'b0);
            vectors++;
            if (key_down !== 1'b0 || key_scan_L !== frozen || kbcode !== 8'h08 || dut_obs() !== exp_obs()) begin
                miscompares++;
                $display("FAIL scan_disable %0d: down=%b scan=%h kbcode=%h expected down=0 scan=%h kbcode=08",
                         i, key_down, key_scan_L, kbcode, frozen);
            end
        end
        for (int i = 0; i < 70; i++) begin
            do_step(1'b1, 1'b1);
            vectors++;
            if (dut_obs() !== exp_obs()) begin
                miscompares++;
                $display("FAIL scan_reenable step %0d: got %h expected %h", i, dut_obs(), exp_obs());
            end
        end
        keys[6'h08] = 1'b0;
        for (int i = 0; i < 64; i++) do_step(1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_debounce();
        debounce_en = 1'b1;
        keys[6'h1C] = 1'b1;
        goto_cnt(6'h1C);
        for (int i = 0; i < 10; i++) do_step(1'b1, 1'b1);
        #3;
        rst_L = 1'b0;
        #1;
        vectors++;
        if (dut_obs() !== {6'h3F, 8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_mid_debounce: got %h expected %h", dut_obs(), {6'h3F, 8'h00, 1'b0, 1'b0});
        end
        model_reset();
        keys = '0;
        @(posedge clk);
        #1;
        rst_L = 1'b1;
        for (int i = 0; i < 80; i++) begin
            do_step(1'b1, 1'b1);
            vectors++;
            if (dut_obs() !== exp_obs()) begin
                miscompares++;
                $display("FAIL after_reset step %0d: got %h expected %h", i, dut_obs(), exp_obs());
            end
        end
    endtask

    task automatic test_random();
        int k;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(99) < 2) begin
                k = $urandom_range(63);
                keys[k] = ~keys[k];
            end
            if ($urandom_range(199) == 0) debounce_en = ~debounce_en;
            if ($urandom_range(299) == 0) shift_key = ~shift_key;
            if ($urandom_range(299) == 0) ctrl_key = ~ctrl_key;
            do_step($urandom_range(1) == 1, $urandom_range(31) != 0);
            vectors++;
            if (dut_obs() !== exp_obs()) begin
                miscompares++;
                $display("FAIL random step %0d: got %h expected %h", i, dut_obs(), exp_obs());
            end
        end
        keys = '0;
        shift_key = 1'b0;
        ctrl_key  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_debounce_on();
        test_glitch();
        test_debounce_off();
        test_second_key();
        test_wrap_and_disable();
        test_reset_mid_debounce();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
